block_stream_gen: RTL
=====================

Name: block_stream_gen

Overview:
Successor to the camera-driven platform block generator. Tracks which vertical block the camera occupies, stepping the block index one block per cycle with no combinational divider. Maps each index to a layout type, then streams that layout's platform descriptors one per beat over a valid/ready interface. Sits between the camera/physics unit and the platform collision/render units, replacing the wide parallel platform buses.

Parameters:
BLOCK_NUM, 7, number of distinct layout types (table holds types 0-6 plus default layout)
PLATFORM_NUM_PER_BLOCK, 7, platforms per layout (descriptor beats per stream)
PHY_WIDTH, 16, physical coordinate width
CAMERA_WIDTH, 6, width of camera_y block-index output
BLOCK_WIDTH, 480, block height in physical units (also horizontal extent used for mirroring)
BLOCK_LEN_WIDTH, 4, platform length field width
TYPE_SEED, 11, offset added to block index before mod BLOCK_NUM

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset, synchronous, active-low
abs_camera_y  in  PHY_WIDTH+1 (signed)  absolute camera y
camera_y  out  CAMERA_WIDTH  current block index, truncated
cur_block_type  out  4  (block_idx + TYPE_SEED) mod BLOCK_NUM
block_switch  out  1  one-cycle pulse per block step
switch_up  out  1  direction of last step (1 = up); valid with block_switch, held after
plat_valid  out  1  descriptor beat valid
plat_ready  in  1  consumer accepts beat
plat_idx  out  3  platform index within layout (0..PLATFORM_NUM_PER_BLOCK-1)
plat_x  out  PHY_WIDTH  platform relative x
plat_y  out  PHY_WIDTH  platform relative y
plat_len  out  BLOCK_LEN_WIDTH  platform length
plat_last  out  1  high on final beat (plat_idx = PLATFORM_NUM_PER_BLOCK-1)

Behaviour:
- Reset (sys_rst_n low at sys_clk edge): block_idx=0, block_base=0, type counter = TYPE_SEED mod BLOCK_NUM (4 with defaults), camera_y=0, block_switch=0, switch_up=0, plat_valid=0, plat_idx=0, plat_x/y/len=0, plat_last=0, restart_pending=1.
- Clamp: y_pos = 0 if abs_camera_y < 0, else abs_camera_y[PHY_WIDTH-1:0].
- block_base kept PHY_WIDTH+1 bits so base+BLOCK_WIDTH cannot overflow.
- Tracker, each cycle:
  - If y_pos >= block_base+BLOCK_WIDTH: idx+1, base+BLOCK_WIDTH, type+1 wrapping at BLOCK_NUM, block_switch=1, switch_up=1.
  - Else if y_pos < block_base: idx-1, base-BLOCK_WIDTH, type-1 wrapping to BLOCK_NUM-1, block_switch=1, switch_up=0.
  - Else block_switch=0.
  - One step per cycle; a jump of k blocks takes k cycles and produces k pulses.
- Outputs registered; camera_y/cur_block_type reflect the new index in the same cycle block_switch is high.
- Stream FSM, states IDLE and STREAM:
  - Any block_switch pulse sets restart_pending.
  - IDLE with restart_pending: latch stream_type = cur_block_type, go to STREAM at plat_idx 0, clear pending. First beat is valid the next cycle.
  - STREAM: beat fields come from the layout table at (stream_type, plat_idx). Fields are registered and held stable while plat_valid && !plat_ready.
  - On handshake (valid && ready):
    - If restart_pending: restart at idx 0 with the current type, no idle cycle.
    - Else if plat_last: go to IDLE, plat_valid=0.
    - Else plat_idx+1.
  - A switch never drops or alters an unaccepted beat.
  - Throughput: one beat per cycle when plat_ready is held high.
- Reset mid-stream: returns to the reset state; the stream restarts from idx 0 after release.
- stream_type >= BLOCK_NUM is unreachable; the table default entry still applies.

Optional Feature:
BLOCK_MIRROR_EN: when defined, beats for odd block_idx (latched at stream start) output plat_x = BLOCK_WIDTH-1-x_table; even indices are unchanged. When undefined, plat_x is always x_table and no mirror logic is built.

Test Plan:
- Reset, abs_camera_y=0, plat_ready=1 -> cur_block_type=4, camera_y=0; beats 0..6 on consecutive cycles, beat 0 = (240,20,10), plat_last only on beat 6, then plat_valid=0.
- Step abs_camera_y 0->480 -> next cycle block_switch pulse, switch_up=1, camera_y=1, cur_block_type=5; new stream beat 0 = (230,30,7).
- Step 0->1500 -> three consecutive pulses, camera_y=3, cur_block_type=0 (base 1440). Then y 1500->100 -> three pulses with switch_up=0, back to type 4.
- abs_camera_y=-50 -> clamped, no block_switch, camera_y stays 0.
- Hold plat_ready=0 at beat 2 while a step occurs -> beat 2 fields stable until ready; on accept, next beat is idx 0 of the new type.
- With BLOCK_MIRROR_EN defined, camera at block 1 -> beat 0 plat_x=249 (480-1-230); block 2 beats unmirrored.

Source files
------------

// File: rtl/block_stream_gen_if.sv
// -----------------------------------------------------------------------------
// block_stream_gen_if
//   Platform descriptor stream between block_stream_gen (master) and the
//   collision/render consumers (slave).
//
//   Handshake: a beat transfers on any sys_clk edge where plat_valid and
//   plat_ready are both high. Once plat_valid is raised it stays high, and
//   plat_idx/plat_x/plat_y/plat_len/plat_last stay unchanged, until that beat
//   transfers. plat_ready may change freely and never depends on plat_valid
//   combinationally.
//
//   Signals:
//     plat_valid  master->slave  beat valid
//     plat_ready  slave->master  consumer accepts beat
//     plat_idx    master->slave  platform index within the layout
//     plat_x      master->slave  platform relative x
//     plat_y      master->slave  platform relative y
//     plat_len    master->slave  platform length
//     plat_last   master->slave  final beat of the layout
// -----------------------------------------------------------------------------
interface block_stream_gen_if #(
  parameter int PHY_WIDTH       = 16,
  parameter int BLOCK_LEN_WIDTH = 4
);
  logic                       plat_valid;
  logic                       plat_ready;
  logic [2:0]                 plat_idx;
  logic [PHY_WIDTH-1:0]       plat_x;
  logic [PHY_WIDTH-1:0]       plat_y;
  logic [BLOCK_LEN_WIDTH-1:0] plat_len;
  logic                       plat_last;

  modport master (
    output plat_valid, plat_idx, plat_x, plat_y, plat_len, plat_last,
    input  plat_ready
  );

  modport slave (
    input  plat_valid, plat_idx, plat_x, plat_y, plat_len, plat_last,
    output plat_ready
  );
endinterface

// File: rtl/block_stream_gen.sv
// -----------------------------------------------------------------------------
// block_stream_gen
//   Tracks the vertical block the camera occupies (one block step per cycle,
//   no divider), maps the block index to a layout type and streams that
//   layout's platform descriptors one per beat over block_stream_gen_if.
//
//   Optional feature macro: BLOCK_MIRROR_EN
//     When defined, streams that start while block_idx is odd output
//     plat_x = BLOCK_WIDTH-1-x_table. When undefined no mirror logic exists.
//
//   Ports:
//     sys_clk         clock
//     sys_rst_n       synchronous active-low reset
//     abs_camera_y    absolute camera y (signed, negative clamps to 0)
//     camera_y        current block index, truncated to CAMERA_WIDTH
//     cur_block_type  (block_idx + TYPE_SEED) mod BLOCK_NUM
//     block_switch    one-cycle pulse per block step
//     switch_up       direction of last step (1 = up), held between steps
//     dbg_streaming   stream FSM state (1 = STREAM, 0 = IDLE)
//     plat            descriptor stream, master side
// -----------------------------------------------------------------------------
module block_stream_gen #(
  parameter int BLOCK_NUM              = 7,
  parameter int PLATFORM_NUM_PER_BLOCK = 7,
  parameter int PHY_WIDTH              = 16,
  parameter int CAMERA_WIDTH           = 6,
  parameter int BLOCK_WIDTH            = 480,
  parameter int BLOCK_LEN_WIDTH        = 4,
  parameter int TYPE_SEED              = 11
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic signed [PHY_WIDTH:0]   abs_camera_y,
  output logic [CAMERA_WIDTH-1:0]     camera_y,
  output logic [3:0]                  cur_block_type,
  output logic                        block_switch,
  output logic                        switch_up,
  output logic                        dbg_streaming,
  block_stream_gen_if.master          plat
);

  localparam logic [3:0] TYPE_RESET = 4'(TYPE_SEED % BLOCK_NUM);
  localparam logic [3:0] TYPE_MAX   = 4'(BLOCK_NUM - 1);
  localparam logic [2:0] LAST_IDX   = 3'(PLATFORM_NUM_PER_BLOCK - 1);
  localparam logic [PHY_WIDTH:0] BASE_STEP = (PHY_WIDTH+1)'(BLOCK_WIDTH);

  // Layout table: rows 0-6 are the layout types, row 7 is the default layout.
  // Column 7 is padding so a 3-bit index always lands inside the row.
  localparam int X_TAB [0:7][0:7] = '{
    '{ 40, 120, 200, 280, 360, 100, 300, 0},
    '{ 60, 160, 260, 360,  80, 180, 280, 0},
    '{100, 220, 340,  60, 180, 300, 400, 0},
    '{ 20, 140, 260, 380, 200,  80, 320, 0},
    '{240, 120, 360,  60, 300, 180, 400, 0},
    '{230,  90, 330, 150, 390,  30, 270, 0},
    '{ 50, 170, 290, 410, 110, 230, 350, 0},
    '{240, 240, 240, 240, 240, 240, 240, 0}
  };
  localparam int Y_TAB [0:7][0:7] = '{
    '{ 20,  80, 140, 200, 260, 320, 400, 0},
    '{ 30,  90, 150, 210, 270, 330, 410, 0},
    '{ 25,  85, 145, 205, 265, 325, 405, 0},
    '{ 35,  95, 155, 215, 275, 335, 415, 0},
    '{ 20,  80, 140, 200, 260, 320, 400, 0},
    '{ 30,  90, 150, 210, 270, 330, 410, 0},
    '{ 40, 100, 160, 220, 280, 340, 420, 0},
    '{  0,  70, 140, 210, 280, 350, 420, 0}
  };
  localparam int L_TAB [0:7][0:7] = '{
    '{  8,   6,  10,   5,   7,   9,   4, 0},
    '{  6,   8,   5,  10,   7,   6,   9, 0},
    '{  9,   5,   7,   8,   6,  10,   5, 0},
    '{  7,   9,   6,   8,  10,   5,   6, 0},
    '{ 10,   6,   8,   7,   5,   9,   6, 0},
    '{  7,   8,   6,   9,   5,  10,   7, 0},
    '{  5,   7,   9,   6,   8,  10,   4, 0},
    '{  8,   8,   8,   8,   8,   8,   8, 0}
  };

  // ---------------------------------------------------------------------------
  // Block tracker
  // ---------------------------------------------------------------------------
  logic [PHY_WIDTH-1:0] y_pos;
  logic [PHY_WIDTH:0]   block_base;   // one extra bit so base+BLOCK_WIDTH never wraps
  logic [PHY_WIDTH:0]   base_hi;
  logic [PHY_WIDTH-1:0] block_idx;
  logic [3:0]           type_cnt;
  logic                 step_up;
  logic                 step_dn;

  always_comb begin
    y_pos   = abs_camera_y[PHY_WIDTH] ? '0 : abs_camera_y[PHY_WIDTH-1:0];
    base_hi = block_base + BASE_STEP;
    step_up = {1'b0, y_pos} >= base_hi;
    step_dn = {1'b0, y_pos} < block_base;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      block_idx    <= '0;
      block_base   <= '0;
      type_cnt     <= TYPE_RESET;
      block_switch <= 1'b0;
      switch_up    <= 1'b0;
    end else if (step_up) begin
      block_idx    <= block_idx + PHY_WIDTH'(1);
      block_base   <= base_hi;
      type_cnt     <= (type_cnt == TYPE_MAX) ? 4'd0 : type_cnt + 4'd1;
      block_switch <= 1'b1;
      switch_up    <= 1'b1;
    end else if (step_dn) begin
      block_idx    <= block_idx - PHY_WIDTH'(1);
      block_base   <= block_base - BASE_STEP;
      type_cnt     <= (type_cnt == 4'd0) ? TYPE_MAX : type_cnt - 4'd1;
      block_switch <= 1'b1;
      switch_up    <= 1'b0;
    end else begin
      block_switch <= 1'b0;
    end
  end

  assign camera_y       = block_idx[CAMERA_WIDTH-1:0];
  assign cur_block_type = type_cnt;

  // ---------------------------------------------------------------------------
  // Stream FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t     state;
  logic       restart_pending;
  logic [3:0] stream_type;
`ifdef BLOCK_MIRROR_EN
  logic       stream_odd;
`endif

  // A pulse arriving this cycle counts as pending so it is never lost.
  logic                       pending_eff;
  logic                       hs;
  logic                       load_en;
  logic                       load_start;
  logic [2:0]                 load_idx;
  logic [3:0]                 lk_type;
  logic [2:0]                 lk_sel;
  logic [PHY_WIDTH-1:0]       lk_x;
  logic [PHY_WIDTH-1:0]       lk_y;
  logic [BLOCK_LEN_WIDTH-1:0] lk_len;

  always_comb begin
    pending_eff = restart_pending | block_switch;
    hs          = plat.plat_valid & plat.plat_ready;
    load_en     = 1'b0;
    load_start  = 1'b0;
    load_idx    = 3'd0;
    case (state)
      S_IDLE: begin
        if (pending_eff) begin
          load_en    = 1'b1;
          load_start = 1'b1;
        end
      end
      S_STREAM: begin
        if (hs) begin
          if (pending_eff) begin
            load_en    = 1'b1;
            load_start = 1'b1;
          end else if (!plat.plat_last) begin
            load_en  = 1'b1;
            load_idx = plat.plat_idx + 3'd1;
          end
        end
      end
      default: ;
    endcase

    lk_type = load_start ? cur_block_type : stream_type;
    lk_sel  = (lk_type < 4'(BLOCK_NUM)) ? lk_type[2:0] : 3'd7;
    lk_x    = PHY_WIDTH'(X_TAB[lk_sel][load_idx]);
    lk_y    = PHY_WIDTH'(Y_TAB[lk_sel][load_idx]);
    lk_len  = BLOCK_LEN_WIDTH'(L_TAB[lk_sel][load_idx]);
`ifdef BLOCK_MIRROR_EN
    // Parity comes from the live index at stream start, latched afterwards.
    if (load_start ? block_idx[0] : stream_odd)
      lk_x = PHY_WIDTH'(BLOCK_WIDTH - 1) - lk_x;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state           <= S_IDLE;
      restart_pending <= 1'b1;
      stream_type     <= '0;
      plat.plat_valid <= 1'b0;
      plat.plat_idx   <= '0;
      plat.plat_x     <= '0;
      plat.plat_y     <= '0;
      plat.plat_len   <= '0;
      plat.plat_last  <= 1'b0;
`ifdef BLOCK_MIRROR_EN
      stream_odd      <= 1'b0;
`endif
    end else begin
      restart_pending <= pending_eff & ~load_start;

      case (state)
        S_IDLE: begin
          if (load_start) begin
            state           <= S_STREAM;
            plat.plat_valid <= 1'b1;
          end
        end
        S_STREAM: begin
          if (hs && !pending_eff && plat.plat_last) begin
            state           <= S_IDLE;
            plat.plat_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (load_start) begin
        stream_type <= cur_block_type;
`ifdef BLOCK_MIRROR_EN
        stream_odd  <= block_idx[0];
`endif
      end

      if (load_en) begin
        plat.plat_idx  <= load_idx;
        plat.plat_x    <= lk_x;
        plat.plat_y    <= lk_y;
        plat.plat_len  <= lk_len;
        plat.plat_last <= (load_idx == LAST_IDX);
      end
    end
  end

  assign dbg_streaming = (state == S_STREAM);

endmodule
